// File: rtl/decodificador_pkg.sv
// rtl/decodificador_pkg.sv - shared mode encodings and state type for decodificador_seq
//
// Purpose: holds the two-bit mode encodings and the controller state type.
// Ports:   none (package).

package decodificador_pkg;

   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_PULSE  = 2'b01;
   localparam logic [1:0] MODE_SCAN   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_HOLD  = 2'b01,
      ST_PULSE = 2'b10,
      ST_SCAN  = 2'b11
   } state_t;

endpackage

// File: rtl/decodificador_core.sv
// rtl/decodificador_core.sv - combinational code to one-hot converter
//
// Purpose: converts a W_IN-bit code into an N_OUT-bit one-hot vector.
//          Codes >= N_OUT produce an all-zero vector.
// Ports:
//   code   in  [W_IN-1:0]   code to convert
//   onehot out [N_OUT-1:0]  one-hot result, zero when out of range

module decodificador_core #(
   parameter int W_IN  = 3,
   parameter int N_OUT = 8
) (
   input  logic [W_IN-1:0]  code,
   output logic [N_OUT-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N_OUT; i++) begin
         onehot[i] = (code == W_IN'(i));
      end
   end

endmodule

// File: rtl/decodificador_seq.sv
// rtl/decodificador_seq.sv - registered decoder with direct, pulse and scan modes
//
// Purpose: decodes accepted codes to a registered one-hot output. Direct mode
//          holds the decode, pulse mode shows it for PULSE_LEN enabled cycles,
//          scan mode walks a single bit across the output.
// Ports:
//   clk       in               rising-edge clock
//   rst       in               synchronous active-high reset
//   en        in               global enable, freezes all state when low
//   mode      in  [1:0]        00 direct, 01 pulse, 10 scan, 11 as direct
//   A         in  [W_IN-1:0]   code to decode
//   in_valid  in               A is valid this cycle
//   in_ready  out              A is accepted this cycle (combinational)
//   S         out [N_OUT-1:0]  registered one-hot or zero output
//   out_valid out              S holds a valid decode
//   erro      out              one-cycle out-of-range flag

module decodificador_seq
   import decodificador_pkg::*;
#(
   parameter int W_IN      = 3,
   parameter int N_OUT     = 8,
   parameter int PULSE_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [W_IN-1:0]  A,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N_OUT-1:0] S,
   output logic             out_valid,
   output logic             erro
);

   localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [N_OUT-1:0]   s_nxt;
   logic               ov_nxt;
   logic               erro_nxt;
   logic [N_OUT-1:0]   dec;
   logic               in_range;
   logic               accept;

   decodificador_core #(
      .W_IN  (W_IN),
      .N_OUT (N_OUT)
   ) u_core (
      .code   (A),
      .onehot (dec)
   );

   // An all-zero decode is exactly the out-of-range case.
   assign in_range = |dec;

   assign in_ready = en && (state == ST_IDLE || state == ST_HOLD) && (mode != MODE_SCAN);
   assign accept   = in_valid && in_ready;

   always_comb begin
      s_nxt     = S;
      ov_nxt    = out_valid;
      erro_nxt  = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;
      if (en) begin
         case (state)
            ST_IDLE, ST_HOLD: begin
               if (mode == MODE_SCAN) begin
                  s_nxt     = N_OUT'(1);
                  ov_nxt    = 1'b1;
                  state_nxt = ST_SCAN;
               end else if (accept) begin
                  if (!in_range) begin
                     s_nxt     = '0;
                     ov_nxt    = 1'b0;
                     erro_nxt  = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     s_nxt  = dec;
                     ov_nxt = 1'b1;
                     if (mode == MODE_PULSE) begin
                        // Counter counts the remaining visible cycles after this one.
                        state_nxt = ST_PULSE;
                        cnt_nxt   = CNT_W'(PULSE_LEN - 1);
                     end else begin
                        state_nxt = ST_HOLD;
                     end
                  end
               end
            end
            ST_PULSE: begin
               // Mode is ignored here so a pulse always runs to completion.
               if (cnt == '0) begin
                  s_nxt     = '0;
                  ov_nxt    = 1'b0;
                  state_nxt = ST_IDLE;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            ST_SCAN: begin
               if (mode != MODE_SCAN) begin
                  s_nxt     = '0;
                  ov_nxt    = 1'b0;
                  state_nxt = ST_IDLE;
               end else begin
                  s_nxt = {S[N_OUT-2:0], S[N_OUT-1]};
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         S         <= '0;
         out_valid <= 1'b0;
         erro      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         S         <= s_nxt;
         out_valid <= ov_nxt;
         erro      <= erro_nxt;
      end
   end

endmodule

// File: tb/tb_decodificador_seq.sv
// tb/tb_decodificador_seq.sv - self-checking bench for decodificador_seq (N_OUT=8 and N_OUT=6)

module tb_decodificador_seq;

   localparam int PL = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [2:0] A;
   logic       in_valid;

   logic       rdy8, ov8, err8;
   logic [7:0] s8;
   logic       rdy6, ov6, err6;
   logic [5:0] s6;

   int n_checks = 0;
   int n_errors = 0;
   bit armed = 0;

   decodificador_seq #(.W_IN(3), .N_OUT(8), .PULSE_LEN(PL)) dut8 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .A(A), .in_valid(in_valid),
      .in_ready(rdy8), .S(s8), .out_valid(ov8), .erro(err8)
   );

   decodificador_seq #(.W_IN(3), .N_OUT(6), .PULSE_LEN(PL)) dut6 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .A(A), .in_valid(in_valid),
      .in_ready(rdy6), .S(s6), .out_valid(ov6), .erro(err6)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: per instance, the shown code index (-1 = none),
   // remaining pulse cycles and whether a scan is running.
   int nout[2] = '{8, 6};
   int m_code[2];
   bit m_ov[2];
   bit m_err[2];
   int m_pulse[2];
   bit m_scan[2];

   function automatic logic [31:0] exp_s(input int code);
      logic [31:0] one;
      one = 32'd1;
      return (code < 0) ? 32'd0 : (one << code);
   endfunction

   function automatic bit exp_ready(input int k);
      return en && (m_pulse[k] == 0) && !m_scan[k] && (mode != 2'b10);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_code[k] = -1; m_ov[k] = 0; m_err[k] = 0; m_pulse[k] = 0; m_scan[k] = 0;
         end else if (!en) begin
            m_err[k] = 0;
         end else begin
            m_err[k] = 0;
            if (m_pulse[k] > 0) begin
               m_pulse[k]--;
               if (m_pulse[k] == 0) begin
                  m_code[k] = -1; m_ov[k] = 0;
               end
            end else if (m_scan[k]) begin
               if (mode != 2'b10) begin
                  m_scan[k] = 0; m_code[k] = -1; m_ov[k] = 0;
               end else begin
                  m_code[k] = (m_code[k] + 1) % nout[k];
               end
            end else if (mode == 2'b10) begin
               m_scan[k] = 1; m_code[k] = 0; m_ov[k] = 1;
            end else if (in_valid) begin
               if (int'(A) >= nout[k]) begin
                  m_code[k] = -1; m_ov[k] = 0; m_err[k] = 1;
               end else begin
                  m_code[k] = int'(A); m_ov[k] = 1;
                  if (mode == 2'b01) m_pulse[k] = PL;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("m8_S", {24'd0, s8}, exp_s(m_code[0]));
         chk("m8_out_valid", {31'd0, ov8}, {31'd0, m_ov[0]});
         chk("m8_erro", {31'd0, err8}, {31'd0, m_err[0]});
         chk("m8_in_ready", {31'd0, rdy8}, {31'd0, exp_ready(0)});
         chk("m6_S", {26'd0, s6}, exp_s(m_code[1]));
         chk("m6_out_valid", {31'd0, ov6}, {31'd0, m_ov[1]});
         chk("m6_erro", {31'd0, err6}, {31'd0, m_err[1]});
         chk("m6_in_ready", {31'd0, rdy6}, {31'd0, exp_ready(1)});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] dir_lit [8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
   logic [7:0] scan_lit[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

   initial begin
      rst = 1; en = 1; mode = 2'b00; A = 3'd0; in_valid = 0;
      step();
      step();
      rst = 0;
      armed = 1;
      #1;
      chk("reset_S", {24'd0, s8}, 32'h00);
      chk("reset_out_valid", {31'd0, ov8}, 32'd0);
      chk("reset_erro", {31'd0, err8}, 32'd0);
      chk("reset_in_ready", {31'd0, rdy8}, 32'd1);

      // Direct, back to back codes 0..7.
      for (int i = 0; i < 8; i++) begin
         A = 3'(i); in_valid = 1; mode = 2'b00;
         step();
         chk("direct_S", {24'd0, s8}, {24'd0, dir_lit[i]});
         chk("direct_out_valid", {31'd0, ov8}, 32'd1);
      end
      in_valid = 0;
      step();

      // Pulse, A=3.
      mode = 2'b01; A = 3'd3; in_valid = 1;
      step();
      in_valid = 0;
      for (int i = 0; i < PL; i++) begin
         chk("pulse_S", {24'd0, s8}, 32'h08);
         chk("pulse_in_ready", {31'd0, rdy8}, 32'd0);
         if (i < PL - 1) step();
      end
      step();
      chk("pulse_end_S", {24'd0, s8}, 32'h00);
      chk("pulse_end_in_ready", {31'd0, rdy8}, 32'd1);

      // Scan for 10 cycles, then leave scan.
      mode = 2'b10;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("scan_S", {24'd0, s8}, {24'd0, scan_lit[i]});
      end
      mode = 2'b00;
      step();
      chk("scan_exit_S", {24'd0, s8}, 32'h00);
      chk("scan_exit_out_valid", {31'd0, ov8}, 32'd0);

      // Out-of-range on the six-output instance.
      A = 3'd6; in_valid = 1; mode = 2'b00;
      step();
      in_valid = 0;
      chk("oor_S", {26'd0, s6}, 32'h00);
      chk("oor_erro", {31'd0, err6}, 32'd1);
      chk("oor_out_valid", {31'd0, ov6}, 32'd0);
      step();
      chk("oor_erro_clear", {31'd0, err6}, 32'd0);

      // Pulse A=5 with three disabled cycles in the middle.
      mode = 2'b01; A = 3'd5; in_valid = 1;
      step();
      in_valid = 0;
      chk("pfreeze_c1", {24'd0, s8}, 32'h20);
      step();
      chk("pfreeze_c2", {24'd0, s8}, 32'h20);
      en = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pfreeze_hold", {24'd0, s8}, 32'h20);
      end
      en = 1;
      step();
      chk("pfreeze_c3", {24'd0, s8}, 32'h20);
      step();
      chk("pfreeze_c4", {24'd0, s8}, 32'h20);
      step();
      chk("pfreeze_end", {24'd0, s8}, 32'h00);

      // Reset during scan.
      mode = 2'b10;
      step();
      step();
      rst = 1;
      step();
      rst = 0;
      chk("rst_scan_S", {24'd0, s8}, 32'h00);
      chk("rst_scan_out_valid", {31'd0, ov8}, 32'd0);

      // Random traffic checked by the model on every cycle.
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 99) < 2);
         en       = ($urandom_range(0, 9) != 0);
         mode     = ($urandom_range(0, 9) < 6) ? mode : 2'($urandom_range(0, 3));
         A        = 3'($urandom_range(0, 7));
         in_valid = ($urandom_range(0, 3) != 0);
         step();
      end

      armed = 0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decodificador_seq.md
DECODIFICADOR_SEQ -- requirements
Module: decodificador_seq

Interface
REQ-001 The block SHALL have parameter W_IN, default 3, meaning the code input width.
REQ-002 The block SHALL have parameter N_OUT, default 8, meaning the number of one-hot outputs; legal range 2 <= N_OUT <= 2**W_IN.
REQ-003 The block SHALL have parameter PULSE_LEN, default 4, meaning the pulse-mode output hold in cycles; legal range >= 1.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: global enable; when low, all state is frozen.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 direct, 01 pulse, 10 scan, 11 reserved (treated as direct).
REQ-009 The block SHALL have port A, input, W_IN bits: the code to decode.
REQ-010 The block SHALL have port in_valid, input, 1 bit: A is valid this cycle.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the block accepts A this cycle.
REQ-012 The block SHALL have port S, output, N_OUT bits: registered one-hot or all-zero output.
REQ-013 The block SHALL have port out_valid, output, 1 bit: S holds a valid decode.
REQ-014 The block SHALL have port erro, output, 1 bit: one-cycle out-of-range flag.

Function
REQ-015 The block SHALL accept an input only on a cycle where in_valid & in_ready & en; the mode value is sampled at acceptance.
REQ-016 The block SHALL implement states IDLE, HOLD, PULSE and SCAN.
REQ-017 in_ready SHALL be combinational: en & (state is IDLE or HOLD) & (mode != 10).
REQ-018 Direct acceptance with A < N_OUT: on the next cycle S SHALL be one-hot(A) and out_valid SHALL be 1, state HOLD (1-cycle latency); S holds until the next acceptance.
REQ-019 Pulse acceptance with A < N_OUT: S SHALL be one-hot(A) and out_valid SHALL be 1 for exactly PULSE_LEN cycles with in_ready=0; then S=0, out_valid=0, state IDLE.
REQ-020 Scan: in IDLE or HOLD with mode=10 and en=1, the next cycle SHALL have S=bit 0, state SCAN; each following en cycle S rotates one position up and wraps from bit N_OUT-1 to bit 0; out_valid=1; in_valid is ignored.
REQ-021 When mode != 10 in SCAN, the next cycle SHALL have S=0, out_valid=0, state IDLE.
REQ-022 An accepted A >= N_OUT SHALL be consumed with the next cycle S=0, out_valid=0, erro=1 for one cycle only, state IDLE.
REQ-023 A mode change during PULSE SHALL NOT abort the pulse; the new mode applies after it completes.
REQ-024 With en=0, S, out_valid, state and the pulse counter SHALL hold; erro SHALL clear to 0; in_ready SHALL be 0.
REQ-025 Back-to-back direct acceptances SHALL update S on every cycle with no bubble.

Reset
REQ-026 rst=1 at a clock edge SHALL force S=0, out_valid=0, erro=0, the pulse counter to 0 and state IDLE, regardless of en or the current state, including mid-pulse and mid-scan.
REQ-027 The first cycle after reset with en=1 and mode!=10 SHALL have in_ready=1.

Structure
REQ-028 Package decodificador_pkg SHALL hold the mode encodings (MODE_DIRECT, MODE_PULSE, MODE_SCAN) and the state type.
REQ-029 The combinational A-to-one-hot conversion SHALL be a sub-module named decodificador_core (W_IN to N_OUT, zero output for out-of-range codes), instantiated once.
REQ-030 All outputs except in_ready SHALL be registered.

Verification
REQ-031 Reset, then direct mode, A=0..7 consecutively with in_valid=1 -> S=01h,02h,04h,...,80h one cycle after each, out_valid=1, no gaps.
REQ-032 Pulse mode, A=3, PULSE_LEN=4 -> S=08h for exactly 4 cycles, in_ready=0 throughout, then S=00h and in_ready=1.
REQ-033 Scan mode for 10 cycles with N_OUT=8 -> S=01h,02h,...,80h,01h,02h; switching to mode=00 -> S=00h on the next cycle.
REQ-034 N_OUT=6, A=6 accepted -> S=00h, erro=1 for exactly one cycle, out_valid=0.
REQ-035 Pulse with A=5 started, en=0 for 3 cycles mid-pulse -> S stays 20h and the total pulse lasts 4 enabled cycles; rst asserted mid-scan -> S=00h on the next cycle.
